ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
- Instruction fetch unit: the producing end of the CU interface.
- Holds the PC, fetches 32-bit MIPS words from instruction memory over a req/ack handshake, splits each word into the op/func/register/immediate fields the CU and datapath consume, and presents them with a valid/ready handshake.
- On retire, takes the CU's Branch code plus the ALU zero flag and computes the next PC.

Parameters:
- RESET_PC, 32'h0000_3000, PC loaded on reset.
- ADDR_W, 32, PC/address width; fixed at 32 for this core.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  word-aligned fetch address; equals pc
- imem_ack  in  1  memory has returned data on imem_rdata this cycle
- imem_rdata  in  32  fetched instruction word
- instr_valid  out  1  decoded fields below are valid
- instr_ready  in  1  downstream has executed the instruction and retires it
- instr  out  32  raw instruction register
- op  out  6  instr[31:26]
- func  out  6  instr[5:0]
- rs, rt, rd  out  5 each  instr[25:21], [20:16], [15:11]
- shamt  out  5  instr[10:6]
- imm16  out  16  instr[15:0]
- pc  out  32  address of the current instruction
- pc_plus4  out  32  pc+4, for PCtoReg/jal link
- Branch  in  2  CU next-PC select, sampled at retire
- zero  in  1  ALU zero flag, sampled at retire
- jr_target  in  32  rs register value for jump-register
- fault  out  1  sticky misaligned-target fault

Behaviour:
- Reset (asynchronous, rst_n low): state=FETCH, pc=RESET_PC, instr=0, fault=0. While rst_n is low: imem_req=0 and instr_valid=0. Field outputs decode instr, so all read 0.
- States: FETCH, ISSUE, FAULT.
- FETCH:
  - imem_req=1, imem_addr=pc, held stable until ack.
  - On a clk edge with imem_ack=1: instr<=imem_rdata, go to ISSUE.
  - Zero-wait memory (ack in the first FETCH cycle) is legal.
  - imem_ack is ignored in ISSUE and FAULT.
- ISSUE:
  - imem_req=0, instr_valid=1; fields are combinational slices of instr.
  - instr_valid stays high until a clk edge with instr_ready=1. Fields and pc are stable meanwhile.
  - On that edge, compute next PC from Branch and zero:
    - 2'b00: pc+4
    - 2'b01: conditional. If zero=1, pc+4 + (sign_extend(imm16)<<2); else pc+4.
    - 2'b10: jump, {pc_plus4[31:28], instr[25:0], 2'b00}
    - 2'b11: jump register, jr_target
  - If next[1:0]==0: pc<=next, go to FETCH.
  - Otherwise: pc unchanged, fault<=1, go to FAULT.
- FAULT: imem_req=0, instr_valid=0, fault=1. Terminal until reset.
- Arithmetic: all PC sums are modulo 2^32. 32'hFFFF_FFFC+4 wraps to 0 with no fault.
- Throughput: minimum 2 cycles per instruction (FETCH with immediate ack, then ISSUE with immediate ready).
- Reset in any state aborts the handshake immediately. A pending ack arriving after reset is ignored unless the bench re-requests.
- pc_plus4 is always pc+4 combinationally.

Decomposition:
- Shared package cpu_pkg:
  - Branch encodings BR_NONE/BR_COND/BR_JUMP/BR_JR
  - state enum
  - RESET_PC default
  - field bit positions (OP_MSB etc.), also used by the CU
- One natural sub-module: ifu_next_pc, the combinational next-PC/alignment-check unit (inputs pc, instr, Branch, zero, jr_target; outputs next_pc, misaligned).

Test Plan:
- Reset then ack=1 with rdata=32'h2008_0005 (addi):
  - imem_addr=32'h3000 in the first cycle after release.
  - Next cycle: instr_valid=1, op=6'h08, rt=8, imm16=5.
- Sequential flow, Branch=00, ready held 1: four fetches at 0x3000, 0x3004, 0x3008, 0x300C, each 2 cycles apart.
- beq at pc=0x3010, imm16=16'hFFFC:
  - zero=1: next imem_addr=0x3004.
  - zero=0: next imem_addr=0x3014.
- j at pc=0x3020, instr=32'h0800_0C10 with Branch=10: next imem_addr=0x0000_3040.
- Handshake stress:
  - ack delayed 3 cycles: imem_addr is stable throughout.
  - instr_ready low for 5 cycles: fields are unchanged.
  - Asserting rst_n low mid-wait returns imem_addr to 0x3000.
- Branch=11 with jr_target=32'h0000_3002: fault=1, instr_valid=0, no further imem_req until reset.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU encodings: next-PC select codes, IFU states, instruction field positions
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int SH_MSB  = 10;
  localparam int SH_LSB  = 6;
  localparam int FN_MSB  = 5;
  localparam int FN_LSB  = 0;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;
  localparam int TGT_MSB = 25;
  localparam int TGT_LSB = 0;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_COND = 2'b01,
    BR_JUMP = 2'b10,
    BR_JR   = 2'b11
  } branch_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_ISSUE = 2'd1,
    ST_FAULT = 2'd2
  } ifu_state_e;

endpackage

// File: rtl/ifu_next_pc.sv
// rtl/ifu_next_pc.sv - combinational next-PC select and word-alignment check
module ifu_next_pc
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic [1:0]  Branch,
  input  logic        zero,
  input  logic [31:0] jr_target,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  logic [31:0] pc_plus4;
  logic [31:0] br_offset;
  logic        unused_op;

  assign pc_plus4  = pc + 32'd4;
  assign br_offset = {{14{instr[IMM_MSB]}}, instr[IMM_MSB:IMM_LSB], 2'b00};
  assign unused_op = ^instr[OP_MSB:OP_LSB];

  always_comb begin
    next_pc = pc_plus4;
    case (branch_e'(Branch))
      BR_NONE: next_pc = pc_plus4;
      BR_COND: next_pc = zero ? (pc_plus4 + br_offset) : pc_plus4;
      BR_JUMP: next_pc = {pc_plus4[31:28], instr[TGT_MSB:TGT_LSB], 2'b00};
      BR_JR:   next_pc = jr_target;
      default: next_pc = pc_plus4;
    endcase
  end

  // Only a register target can be misaligned; the other paths are word-aligned by construction.
  assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch unit: PC, imem req/ack fetch, field split, valid/ready issue
module ifu_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [5:0]        op,
  output logic [5:0]        func,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        shamt,
  output logic [15:0]       imm16,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  input  logic [1:0]        Branch,
  input  logic              zero,
  input  logic [31:0]       jr_target,
  output logic              fault
);

  ifu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic              fault_q, fault_d;
  logic [31:0]       next_pc;
  logic              misaligned;

  ifu_next_pc u_next_pc (
    .pc         (pc_q),
    .instr      (instr_q),
    .Branch     (Branch),
    .zero       (zero),
    .jr_target  (jr_target),
    .next_pc    (next_pc),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    fault_d = fault_q;
    case (state_q)
      ST_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (instr_ready) begin
          if (misaligned) begin
            fault_d = 1'b1;
            state_d = ST_FAULT;
          end else begin
            pc_d    = next_pc;
            state_d = ST_FETCH;
          end
        end
      end
      default: state_d = ST_FAULT;
    endcase
  end

  // Handshake outputs are gated by rst_n so they drop the instant reset is asserted.
  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    if (rst_n) begin
      imem_req    = (state_q == ST_FETCH);
      instr_valid = (state_q == ST_ISSUE);
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign pc_plus4  = pc_q + ADDR_W'(4);
  assign fault     = fault_q;
  assign instr     = instr_q;
  assign op        = instr_q[OP_MSB:OP_LSB];
  assign rs        = instr_q[RS_MSB:RS_LSB];
  assign rt        = instr_q[RT_MSB:RT_LSB];
  assign rd        = instr_q[RD_MSB:RD_LSB];
  assign shamt     = instr_q[SH_MSB:SH_LSB];
  assign func      = instr_q[FN_MSB:FN_LSB];
  assign imm16     = instr_q[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - directed bench for ifu_fetch with a fetch-address scoreboard
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [5:0]  op, func;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic [31:0] pc, pc_plus4;
  logic [1:0]  Branch;
  logic        zero;
  logic [31:0] jr_target;
  logic        fault;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int fetch_cyc;
  int prev_cyc;
  logic [31:0] cur_pc;
  logic [31:0] cur_instr;
  logic [31:0] exp_q[$];

  ifu_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .op          (op),
    .func        (func),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .shamt       (shamt),
    .imm16       (imm16),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .Branch      (Branch),
    .zero        (zero),
    .jr_target   (jr_target),
    .fault       (fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_expected(output logic [31:0] exp);
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    else exp = 32'hxxxx_xxxx;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20 && imem_req !== 1'b1; i++) @(negedge clk);
    check("fetch_req", {31'd0, imem_req}, 32'd1);
  endtask

  task automatic do_fetch(input logic [31:0] rdata, input int ack_delay);
    logic [31:0] exp;
    wait_req();
    pop_expected(exp);
    check("fetch_addr", imem_addr, exp);
    fetch_cyc = cyc;
    cur_pc    = exp;
    cur_instr = rdata;
    for (int i = 0; i < ack_delay; i++) begin
      imem_ack = 1'b0;
      @(negedge clk);
      check("addr_stable", imem_addr, exp);
      check("req_held", {31'd0, imem_req}, 32'd1);
    end
    imem_ack   = 1'b1;
    imem_rdata = rdata;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    check("issue_valid", {31'd0, instr_valid}, 32'd1);
    check("issue_instr", instr, rdata);
    check("issue_noreq", {31'd0, imem_req}, 32'd0);
  endtask

  task automatic do_retire(input logic [1:0] br, input logic z, input logic [31:0] jr, input int hold);
    for (int i = 0; i < hold; i++) begin
      instr_ready = 1'b0;
      imem_ack    = 1'b1;
      imem_rdata  = ~cur_instr;
      @(negedge clk);
      check("hold_valid", {31'd0, instr_valid}, 32'd1);
      check("hold_instr", instr, cur_instr);
      check("hold_imm16", {16'd0, imm16}, {16'd0, cur_instr[15:0]});
      check("hold_pc", pc, cur_pc);
    end
    imem_ack    = 1'b0;
    Branch      = br;
    zero        = z;
    jr_target   = jr;
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    Branch      = 2'b00;
    zero        = 1'b0;
  endtask

  initial begin
    logic [31:0] exp;
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    Branch = 2'b00; zero = 1'b0; jr_target = '0;
    repeat (2) @(negedge clk);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_pc", pc, 32'h0000_3000);
    check("rst_instr", instr, 32'd0);
    check("rst_op", {26'd0, op}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);

    rst_n = 1'b1;
    exp_q.push_back(32'h0000_3000);
    @(negedge clk);
    do_fetch(32'h2008_0005, 0);
    check("addi_op", {26'd0, op}, 32'h08);
    check("addi_rt", {27'd0, rt}, 32'd8);
    check("addi_rs", {27'd0, rs}, 32'd0);
    check("addi_imm", {16'd0, imm16}, 32'd5);
    check("addi_pc4", pc_plus4, 32'h0000_3004);
    prev_cyc = fetch_cyc;

    exp_q.push_back(32'h0000_3004);
    do_retire(2'b00, 1'b0, 32'd0, 0);
    do_fetch(32'h0128_5020, 0);
    check("seq_gap1", fetch_cyc - prev_cyc, 32'd2);
    check("add_rs", {27'd0, rs}, 32'd9);
    check("add_rd", {27'd0, rd}, 32'd10);
    check("add_shamt", {27'd0, shamt}, 32'd0);
    check("add_func", {26'd0, func}, 32'h20);
    prev_cyc = fetch_cyc;
    exp_q.push_back(32'h0000_3008);
    do_retire(2'b00, 1'b0, 32'd0, 0);
    do_fetch(32'h0000_0000, 0);
    check("seq_gap2", fetch_cyc - prev_cyc, 32'd2);
    prev_cyc = fetch_cyc;
    exp_q.push_back(32'h0000_300C);
    do_retire(2'b00, 1'b0, 32'd0, 0);
    do_fetch(32'h0000_0000, 0);
    check("seq_gap3", fetch_cyc - prev_cyc, 32'd2);

    exp_q.push_back(32'h0000_3010);
    do_retire(2'b00, 1'b0, 32'd0, 0);
    do_fetch(32'h1109_FFFC, 0);
    check("beq_op", {26'd0, op}, 32'h04);
    check("beq_imm", {16'd0, imm16}, 32'h0000_FFFC);
    exp_q.push_back(32'h0000_3004);
    do_retire(2'b01, 1'b1, 32'd0, 0);

    for (int a = 32'h3004; a < 32'h3010; a += 4) begin
      do_fetch(32'h0000_0000, 0);
      exp_q.push_back(a + 4);
      do_retire(2'b00, 1'b0, 32'd0, 0);
    end
    do_fetch(32'h1109_FFFC, 0);
    exp_q.push_back(32'h0000_3014);
    do_retire(2'b01, 1'b0, 32'd0, 0);

    for (int a = 32'h3014; a < 32'h3020; a += 4) begin
      do_fetch(32'h0000_0000, 0);
      exp_q.push_back(a + 4);
      do_retire(2'b00, 1'b0, 32'd0, 0);
    end
    do_fetch(32'h0800_0C10, 0);
    exp_q.push_back(32'h0000_3040);
    do_retire(2'b10, 1'b0, 32'd0, 0);

    do_fetch(32'h8C49_0004, 3);
    exp_q.push_back(32'h0000_3044);
    do_retire(2'b00, 1'b0, 32'd0, 5);

    do_fetch(32'h0000_0000, 0);
    do_retire(2'b11, 1'b0, 32'h0000_3002, 0);
    check("flt_fault", {31'd0, fault}, 32'd1);
    check("flt_valid", {31'd0, instr_valid}, 32'd0);
    check("flt_pc", pc, 32'h0000_3044);
    for (int i = 0; i < 4; i++) begin
      imem_ack = 1'b1;
      @(negedge clk);
      check("flt_noreq", {31'd0, imem_req}, 32'd0);
      check("flt_sticky", {31'd0, fault}, 32'd1);
    end
    imem_ack = 1'b0;

    rst_n = 1'b0;
    #1;
    check("rst2_fault", {31'd0, fault}, 32'd0);
    check("rst2_pc", pc, 32'h0000_3000);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(32'h0000_3000);
    @(negedge clk);
    do_fetch(32'h03E0_0008, 0);
    exp_q.push_back(32'hFFFF_FFFC);
    do_retire(2'b11, 1'b0, 32'hFFFF_FFFC, 0);
    do_fetch(32'h0000_0000, 0);
    check("wrap_pc4", pc_plus4, 32'h0000_0000);
    exp_q.push_back(32'h0000_0000);
    do_retire(2'b00, 1'b0, 32'd0, 0);
    do_fetch(32'h0800_0C10, 0);
    check("wrap_nofault", {31'd0, fault}, 32'd0);
    exp_q.push_back(32'h0000_3040);
    do_retire(2'b10, 1'b0, 32'd0, 0);

    wait_req();
    pop_expected(exp);
    check("midwait_addr", imem_addr, exp);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_addr", imem_addr, 32'h0000_3000);
    check("midrst_req", {31'd0, imem_req}, 32'd0);
    check("midrst_valid", {31'd0, instr_valid}, 32'd0);
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    rst_n = 1'b1;
    exp_q.push_back(32'h0000_3000);
    @(negedge clk);
    do_fetch(32'h2008_0005, 0);
    check("post_rst_op", {26'd0, op}, 32'h08);
    check("sb_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
